hazard_fwd_unit: RTL
====================

Name: hazard_fwd_unit

Overview:
- Parametrised hazard and forwarding controller for the 5-stage RV32I pipeline (IF, ID, EX, MEM, WB).
- Keeps its own shadow copy of the destination-register info for the instructions in EX and MEM.
- Generates four kinds of control: load-use stalls with a configurable stall depth, taken-branch flushes, registered EX-stage forwarding selects, and saturating performance counters.
- Sits beside the IF/ID and ID/EX pipeline registers and drives their hold and clear controls.

Parameters:
- REG_AW, 5: register address width.
- LOAD_STALL, 1: bubbles inserted on a load-use hazard. Legal range 1..4.
- CNT_W, 16: width of each performance counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- id_valid  in  1  a valid instruction is present in ID.
- id_rs1  in  REG_AW  rs1 of the ID instruction.
- id_rs2  in  REG_AW  rs2 of the ID instruction.
- id_use_rs1  in  1  the ID instruction reads rs1.
- id_use_rs2  in  1  the ID instruction reads rs2.
- id_rd  in  REG_AW  rd of the ID instruction.
- id_we  in  1  the ID instruction writes rd.
- id_is_load  in  1  the ID instruction is a load.
- ex_branch_taken  in  1  branch/jump in EX resolved as taken.
- stall_if  out  1  hold the PC and IF/ID register.
- bubble_ex  out  1  load a NOP into ID/EX.
- flush_ifid  out  1  clear IF/ID to a NOP.
- fwd_a  out  2  operand-1 source for the instruction now in EX.
- fwd_b  out  2  operand-2 source for the instruction now in EX.
- stall_cnt  out  CNT_W  count of stall cycles, saturating.
- flush_cnt  out  CNT_W  count of flush events, saturating.

Behaviour:
- Forward encoding:
  - 00: register file (the register file is write-first).
  - 01: EX/MEM result.
  - 10: MEM/WB write-back data.
  - 11: never driven.
- State:
  - sh_ex and sh_mem shadows, each holding {valid, rd, we, is_load}.
  - cnt (3 bits).
  - fwd_a and fwd_b registers.
  - stall_cnt and flush_cnt.
- Reset: all shadows invalid, cnt=0, fwd_a=fwd_b=00, both counters 0. As a result, stall_if, bubble_ex and flush_ifid read 0 while reset is high.
- Source match:
  - A source matches a shadow when: id_valid, use flag=1, rs!=0, shadow valid, shadow we=1, and shadow rd==rs.
  - An sh_ex match takes priority over an sh_mem match.
- Load-use detect (lu): cnt==0 and some used source matches sh_ex with is_load=1.
- Taken flush (tk): ex_branch_taken and sh_ex.valid.
- Combinational outputs:
  - flush_ifid = tk.
  - stall_if = !tk and (lu or cnt!=0).
  - bubble_ex = tk or lu or cnt!=0.
- Counter cnt:
  - If tk, cnt is cleared to 0; the stalled instruction is wrong-path.
  - Otherwise, on lu, cnt is loaded with LOAD_STALL-1.
  - Otherwise, cnt decrements while nonzero.
- Shadow advance, every edge:
  - sh_mem takes sh_ex.
  - sh_ex becomes invalid if bubble_ex, else takes the ID fields.
  - The back end never stalls.
- Forward registers, every edge:
  - If bubble_ex: fwd_a=fwd_b=00.
  - Otherwise each source gets 01 on an sh_ex match, else 10 on an sh_mem match, else 00.
  - A match against a load in sh_mem is legal and gives 10.
- When LOAD_STALL>=2, the load has reached WB when ID is released, so the forward select is 00 (write-first register file).
- Performance counters:
  - stall_cnt increments on each cycle with stall_if=1.
  - flush_cnt increments on each cycle with tk=1.
  - Both hold at 2^CNT_W-1.
- Simultaneous branch taken and load-use: the flush wins; no stall is recorded; the PC takes the branch target.
- Reset asserted mid-stall: all state clears immediately; no residual bubble after reset is released.

Decomposition:
- Shared package (riscv_pipe_pkg):
  - FWD_RF, FWD_EXMEM, FWD_MEMWB constants.
  - Packed shadow_t typedef {valid, rd, we, is_load}.
- One sub-module, fwd_select: combinational source-versus-two-shadows compare returning {match_ex, match_mem, load_ex}. Instantiated twice, once per source.

Test Plan:
1. ALU-to-ALU forwarding: add x5 (ID, then EX), next instruction sub x6,x5,x7 → fwd_a=01 on its EX cycle; no stall; stall_cnt=0.
2. Distance-2 forwarding: add x5, nop, then or x8,x9,x5 → fwd_b=10; no stall.
3. Load-use, LOAD_STALL=1: lw x3, then add x4,x3,x1 → stall_if=1 and bubble_ex=1 for 1 cycle, then fwd_a=10; stall_cnt=1.
4. Load-use, LOAD_STALL=3: same pair → stall for 3 cycles; fwd_a=00 at release; stall_cnt=3.
5. Taken branch together with load-use in ID → flush_ifid=1, bubble_ex=1, stall_if=0, cnt=0; flush_cnt=1.
6. Writes to x0 never forward; reset asserted on the second stall cycle of LOAD_STALL=3 → outputs 0 asynchronously; normal flow after reset is released; with CNT_W=2, 5 stalls leave stall_cnt=3.

Source files
------------

// File: rtl/hazard_fwd_unit_pkg.sv
// Shared pipeline-control types: forward-select encodings and the EX/MEM shadow record.
package riscv_pipe_pkg;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    // rd is stored zero-extended so one shadow layout serves any REG_AW up to this width.
    localparam int unsigned SH_RD_W = 8;

    typedef struct packed {
        logic               valid;
        logic [SH_RD_W-1:0] rd;
        logic               we;
        logic               is_load;
    } shadow_t;

endpackage

// File: rtl/hazard_fwd_unit_if.sv
// ID-stage request and hazard/forward control bundle between the pipeline and the hazard unit.
interface hazard_fwd_unit_if #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic [REG_AW-1:0] id_rd;
    logic              id_we;
    logic              id_is_load;
    logic              ex_branch_taken;

    logic              stall_if;
    logic              bubble_ex;
    logic              flush_ifid;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_we, id_is_load, ex_branch_taken,
        input  stall_if, bubble_ex, flush_ifid, fwd_a, fwd_b, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_we, id_is_load, ex_branch_taken,
        output stall_if, bubble_ex, flush_ifid, fwd_a, fwd_b, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_fwd_unit_fwd_select.sv
// Compares one ID source register against the EX and MEM shadows.
module fwd_select
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic              id_valid,
    input  logic              use_rs,
    input  logic [REG_AW-1:0] rs,
    input  shadow_t           sh_ex,
    input  shadow_t           sh_mem,
    output logic              match_ex,
    output logic              match_mem,
    output logic              load_ex
);

    logic [SH_RD_W-1:0] rs_ext;
    logic               src_live;
    logic               unused_mem_load;

    always_comb begin
        rs_ext          = SH_RD_W'(rs);
        src_live        = id_valid && use_rs && (rs != '0);
        match_ex        = src_live && sh_ex.valid && sh_ex.we && (sh_ex.rd == rs_ext);
        match_mem       = src_live && sh_mem.valid && sh_mem.we && (sh_mem.rd == rs_ext);
        load_ex         = match_ex && sh_ex.is_load;
        unused_mem_load = sh_mem.is_load;
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Load-use stall, taken-branch flush, registered EX forward selects and saturating event counters.
module hazard_fwd_unit
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned LOAD_STALL = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    hazard_fwd_unit_if.slave bus
);

    localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL - 1);

    shadow_t          sh_ex;
    shadow_t          sh_mem;
    shadow_t          id_sh;
    logic [2:0]       cnt;
    logic [1:0]       fwd_a_q;
    logic [1:0]       fwd_b_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    logic a_ex, a_mem, a_ld;
    logic b_ex, b_mem, b_ld;
    logic lu, tk, stall, bubble;
    logic [1:0] sel_a, sel_b;

    fwd_select #(.REG_AW(REG_AW)) u_sel_a (
        .id_valid  (bus.id_valid),
        .use_rs    (bus.id_use_rs1),
        .rs        (bus.id_rs1),
        .sh_ex     (sh_ex),
        .sh_mem    (sh_mem),
        .match_ex  (a_ex),
        .match_mem (a_mem),
        .load_ex   (a_ld)
    );

    fwd_select #(.REG_AW(REG_AW)) u_sel_b (
        .id_valid  (bus.id_valid),
        .use_rs    (bus.id_use_rs2),
        .rs        (bus.id_rs2),
        .sh_ex     (sh_ex),
        .sh_mem    (sh_mem),
        .match_ex  (b_ex),
        .match_mem (b_mem),
        .load_ex   (b_ld)
    );

    always_comb begin
        lu     = (cnt == '0) && (a_ld || b_ld);
        tk     = bus.ex_branch_taken && sh_ex.valid;
        stall  = !tk && (lu || (cnt != '0));
        bubble = tk || lu || (cnt != '0);

        sel_a = a_ex ? FWD_EXMEM : (a_mem ? FWD_MEMWB : FWD_RF);
        sel_b = b_ex ? FWD_EXMEM : (b_mem ? FWD_MEMWB : FWD_RF);

        id_sh.valid   = bus.id_valid;
        id_sh.rd      = SH_RD_W'(bus.id_rd);
        id_sh.we      = bus.id_we;
        id_sh.is_load = bus.id_is_load;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_ex       <= '0;
            sh_mem      <= '0;
            cnt         <= '0;
            fwd_a_q     <= FWD_RF;
            fwd_b_q     <= FWD_RF;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            // The back end never stalls, so the shadows advance every cycle.
            sh_mem <= sh_ex;
            sh_ex  <= bubble ? shadow_t'('0) : id_sh;

            // A taken branch makes the stalled ID instruction wrong-path.
            if (tk)
                cnt <= '0;
            else if (lu)
                cnt <= STALL_RELOAD;
            else if (cnt != '0)
                cnt <= cnt - 3'd1;

            fwd_a_q <= bubble ? FWD_RF : sel_a;
            fwd_b_q <= bubble ? FWD_RF : sel_b;

            if (stall && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (tk && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign bus.stall_if   = stall;
    assign bus.bubble_ex  = bubble;
    assign bus.flush_ifid = tk;
    assign bus.fwd_a      = fwd_a_q;
    assign bus.fwd_b      = fwd_b_q;
    assign bus.stall_cnt  = stall_cnt_q;
    assign bus.flush_cnt  = flush_cnt_q;

endmodule
